// File: rtl/psi_stream_intersect.sv
// Streaming set-bitmap fold: ANDs or ORs a variable number of W-bit bitmaps per job,
// then popcounts the result CHUNK bits per cycle and holds it until accepted.
module psi_stream_intersect #(
    parameter int W     = 32,
    parameter int CHUNK = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mode_i,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_set,
    output logic [$clog2(W+1)-1:0] out_card,
    output logic [CNT_W-1:0]       out_count,
    output logic                   out_ovf
);
    localparam int NCH   = (W + CHUNK - 1) / CHUNK;
    localparam int PADW  = NCH * CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW    = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, ACC, POPC, OUT} state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       acc_q, acc_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [CW-1:0]      card_q, card_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [PADW-1:0]    acc_pad;
    logic [CHUNK-1:0]   chunk;
    logic [CW-1:0]      chunk_cnt;

    // Zero-extend so the final partial chunk reads its missing bits as 0.
    always_comb begin
        acc_pad   = PADW'(acc_q);
        chunk     = acc_pad[idx_q*CHUNK +: CHUNK];
        chunk_cnt = '0;
        for (int i = 0; i < CHUNK; i++) chunk_cnt = chunk_cnt + CW'(chunk[i]);
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mode_d    = mode_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        card_d    = card_q;
        idx_d     = idx_q;
        in_ready  = (state_q == IDLE) || (state_q == ACC);
        out_valid = (state_q == OUT);
        case (state_q)
            IDLE: if (in_valid) begin
                acc_d   = in_data;
                mode_d  = mode_i;
                count_d = CNT_W'(1);
                ovf_d   = 1'b0;
                state_d = in_last ? POPC : ACC;
            end
            ACC: if (in_valid) begin
                acc_d = mode_q ? (acc_q | in_data) : (acc_q & in_data);
                if (count_q == '1) ovf_d = 1'b1;
                else               count_d = count_q + 1'b1;
                state_d = in_last ? POPC : ACC;
            end
            POPC: begin
                card_d = card_q + chunk_cnt;
                idx_d  = idx_q + 1'b1;
                if (idx_q == IDX_W'(NCH - 1)) state_d = OUT;
            end
            OUT: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == POPC && state_q != POPC) begin
            card_d = '0;
            idx_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mode_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            card_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            card_q  <= card_d;
            idx_q   <= idx_d;
        end
    end

    assign out_set   = acc_q;
    assign out_card  = card_q;
    assign out_count = count_q;
    assign out_ovf   = ovf_q;
endmodule
